// File: rtl/wb_dma_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dma_pkg
//  Purpose  : Shared constants and FSM state type for the Wishbone DMA reader.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_dma_pkg;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Wishbone burst type extension
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Reader control states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2,
    FINISH     = 2'd3
  } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_dma_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : wshb_if
//  Purpose  : 32-bit Wishbone bus bundle with master and slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (
    input  clk, rst, ack, err, dat_sm,
    output cyc, stb, we, sel, adr, cti, bte, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, cti, bte, dat_ms,
    output ack, err, dat_sm
  );

endinterface
`default_nettype wire

// File: rtl/wb_dma_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO with occupancy count.
//             DEPTH must be a power of two and at least 2.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; a simultaneous push and pop cancel in count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/wb_dma_reader.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dma_reader
//  Purpose  : Wishbone burst master that reads a block of words from memory
//             and streams them out through a show-ahead FIFO.
//             Build option WB_DMA_READER_ERR_EN: honour bus err and expose a
//             sticky error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_dma_reader
  import wb_dma_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
`ifdef WB_DMA_READER_ERR_EN
  output logic        error,
`endif
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  wshb_if.master      wb_m
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  dma_state_t        state_q, state_d;
  logic [31:0]       cur_adr_q, cur_adr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [31:0]       adr_q, adr_d;
  logic [2:0]        cti_q, cti_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef WB_DMA_READER_ERR_EN
  logic              error_q, error_d;
`endif

  logic              err_in;
  logic [BEAT_W-1:0] beats;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_free;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;

`ifdef WB_DMA_READER_ERR_EN
  assign err_in = wb_m.err;
  assign error  = error_q;
`else
  assign err_in = 1'b0;
`endif

  assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_count;

  // Length of the next burst: a full burst or whatever is left
  always_comb begin
    beats = BEAT_W'(BURST_LEN);
    if (remaining_q < 16'(BURST_LEN)) beats = remaining_q[BEAT_W-1:0];
  end

  // Next-state and bus/control outputs; bus outputs only move at burst start or on ack
  always_comb begin
    state_d     = state_q;
    cur_adr_d   = cur_adr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    adr_d       = adr_q;
    cti_d       = cti_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    push        = 1'b0;
`ifdef WB_DMA_READER_ERR_EN
    error_d     = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_adr_d   = {base_adr[31:2], 2'b00};
          remaining_d = word_count;
          busy_d      = 1'b1;
`ifdef WB_DMA_READER_ERR_EN
          error_d     = 1'b0;
`endif
          state_d     = (word_count != 16'd0) ? WAIT_SPACE : FINISH;
        end
      end
      WAIT_SPACE: begin
        // Only commit to a burst once every beat of it is guaranteed a slot
        if (fifo_free >= CNT_W'(beats)) begin
          state_d    = BURST;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          adr_d      = cur_adr_q;
          cti_d      = (beats == BEAT_W'(1)) ? CTI_EOB : CTI_INCR;
          beat_cnt_d = beats;
        end
      end
      BURST: begin
        if (err_in) begin
          // Abort: drop the faulting beat and wind down
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
`ifdef WB_DMA_READER_ERR_EN
          error_d = 1'b1;
`endif
          state_d = FINISH;
        end else if (wb_m.ack) begin
          push        = 1'b1;
          cur_adr_d   = cur_adr_q + 32'd4;
          remaining_d = remaining_q - 16'd1;
          beat_cnt_d  = beat_cnt_q - BEAT_W'(1);
          if (beat_cnt_q == BEAT_W'(1)) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = (remaining_q != 16'd1) ? WAIT_SPACE : FINISH;
          end else begin
            adr_d = adr_q + 32'd4;
            cti_d = (beat_cnt_q == BEAT_W'(2)) ? CTI_EOB : CTI_INCR;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and bus registers; reset tears down any cycle in progress immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_adr_q   <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      cti_q       <= CTI_CLASSIC;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WB_DMA_READER_ERR_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_adr_q   <= cur_adr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      cti_q       <= cti_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef WB_DMA_READER_ERR_EN
      error_q     <= error_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push && !fifo_full),
    .push_data (wb_m.dat_sm),
    .pop       (out_valid && out_ready),
    .rd_data   (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign busy        = busy_q;
  assign done        = done_q;

  assign wb_m.cyc    = cyc_q;
  assign wb_m.stb    = stb_q;
  assign wb_m.adr    = adr_q;
  assign wb_m.cti    = cti_q;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.bte    = BTE_LINEAR;
  assign wb_m.dat_ms = 32'd0;

endmodule
`default_nettype wire

// File: doc/wb_dma_reader.md
# wb_dma_reader

Wishbone master that fetches a contiguous block of 32-bit words from a Wishbone memory slave (the on-chip BlockRAM) using incrementing-address bursts, and presents the words in order on a valid/ready stream. It sits directly upstream of the BlockRAM slave on the Wishbone bus and feeds downstream consumers such as a display or checksum stage. An internal FIFO decouples bus bursts from consumer back-pressure.

## Interface
- `BURST_LEN`, 8: maximum beats per burst; power of two, 1..64.
- `FIFO_DEPTH`, 32: FIFO words; power of two, ≥ `BURST_LEN`.
- `clk` in 1: system clock; identical net to `wb_m.clk`.
- `rst` in 1: asynchronous, active-high reset; identical net to `wb_m.rst`.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_adr` in 32: byte address of the first word; bits [1:0] are forced to 0.
- `word_count` in 16: number of words to read; sampled with `start`.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the last word has been written to the FIFO.
- `out_data` out 32: stream data (show-ahead).
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_data` when `out_valid && out_ready`.
- `wb_m` interface: `wshb_if.master`. Drives `cyc`, `stb`, `we`=0, `sel`=4'hF, `adr`, `cti`, `bte`=2'b00. Samples `ack` and `dat_sm`.

## Operation
- FSM states: IDLE, WAIT_SPACE, BURST, FINISH.
- IDLE: on `start`, latch `base_adr` and `word_count` into `cur_adr` and `remaining`. If `word_count`≠0, go to WAIT_SPACE; otherwise go to FINISH. `start` outside IDLE is ignored.
- WAIT_SPACE: compute `beats = min(BURST_LEN, remaining)`. Go to BURST only when FIFO free entries ≥ `beats`; this guarantees that no acked word is dropped. On entry, assert `cyc`/`stb`.
- BURST: on each `ack`, push `dat_sm` into the FIFO, add 4 to `cur_adr` (wraps modulo 2^32), and decrement `remaining` and the beat counter.
- `cti` is 3'b010 on every beat except the last, which carries 3'b111. A 1-beat burst carries 3'b111 only.
- On the last beat's `ack`, deassert `cyc`/`stb` at that clock edge. Go to WAIT_SPACE if `remaining`>0; otherwise go to FINISH.
- FINISH: pulse `done` for one cycle, drop `busy`, return to IDLE.
- FIFO pop happens on `out_valid && out_ready`. A simultaneous push and pop leaves the occupancy unchanged. An empty FIFO is never popped.
- The FIFO content persists after `done` until the consumer drains it. A new `start` may be accepted while the FIFO still holds data.

## Timing
- Reset values: `cyc`=0, `stb`=0, `adr`=0, `cti`=3'b000, `busy`=0, `done`=0, `out_valid`=0. The FIFO is emptied and the FSM returns to IDLE.
- Asserting `rst` mid-burst drops `cyc`/`stb` immediately (asynchronously). Partial data is discarded.
- All Wishbone outputs are registered. `adr`/`cti` change only on the edge where `ack` is sampled high, or on burst start.
- Latency from `start` to first `stb` is 2 cycles when the FIFO has space.
- There is at least one idle cycle (`cyc`=0) between consecutive bursts.
- `out_valid` rises the cycle after the first push.
- With `word_count`=0, `done` pulses 2 cycles after `start`, with no bus activity.

## Configuration
- `WB_DMA_READER_ERR_EN`
  - Defined: `wb_m.err` is sampled in BURST. On `err` the block:
    - terminates the burst (drops `cyc`/`stb`),
    - discards the beat,
    - sets the sticky output `error` (cleared by the next accepted `start`),
    - goes to FINISH.
  - Undefined: the `error` port is absent and `err` is ignored.

## Structure
- Package `wb_dma_pkg`:
  - `CTI_CLASSIC`=3'b000, `CTI_INCR`=3'b010, `CTI_EOB`=3'b111,
  - `BTE_LINEAR`=2'b00,
  - FSM state enum `dma_state_t`.
- Sub-module `sync_fifo`:
  - parameterised width/depth, show-ahead,
  - outputs `empty`, `full`, `count` (log2(DEPTH)+1 bits, used for the free-space check).

## Test plan
- `base_adr`=0x100, `word_count`=8, `BURST_LEN`=8, BRAM preloaded with i at word i → one burst at addresses 0x100..0x11C with `cti` 010×7 then 111; stream outputs words 64..71; `done` pulses once.
- `word_count`=20, `out_ready`=1 → bursts of 8, 8, 4 beats, each ending with `cti`=111; 20 words in order; idle gap between bursts.
- `word_count`=40, `out_ready`=0, `FIFO_DEPTH`=32 → exactly 32 words fetched, then `cyc` stays low. Raising `out_ready` completes the remaining 8 words with no loss or duplication.
- `word_count`=0 → no `cyc`; `done` pulses 2 cycles after `start`; `start` during `busy` is ignored.
- `rst` asserted on beat 3 of 8 → `cyc`/`stb`/`out_valid` low the same cycle. A following `start` with `word_count`=2 reads a correct 2-beat burst.
- With `WB_DMA_READER_ERR_EN`, slave asserts `err` on beat 2 → burst ends, `error`=1, `done` pulses, 1 word in FIFO.
